// File: rtl/exe_stage.sv
// Execute stage: one-entry pipeline register between ID and MEM, ALU, data SRAM request, forwarding to ID.
// Optional feature macro ES_BUS_SCRUB_EN: zero the pipeline register when it drains with no new instruction.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  // op order: add sub slt sltu and nor or xor sll srl sra lui (one-hot)
  logic [31:0] add_sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sra_res;

  always_comb begin
    add_sub_res = alu_op[1] ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);
    slt_res     = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
    sltu_res    = {31'd0, (alu_src1 < alu_src2)};
    sra_res     = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
    alu_result  = ({32{alu_op[0] | alu_op[1]}} & add_sub_res)
                | ({32{alu_op[2]}}  & slt_res)
                | ({32{alu_op[3]}}  & sltu_res)
                | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                | ({32{alu_op[10]}} & sra_res)
                | ({32{alu_op[11]}} & alu_src2);
  end
endmodule

module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ds_to_es_valid,
  input  logic [147:0] ds_to_es_bus,
  output logic         es_allowin,
  input  logic         ms_allowin,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic [38:0]  es_fw_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);
  // Handshake: an instruction moves across a boundary on a rising edge where the
  // sender's valid and the receiver's allowin are both 1; allowin never depends on valid.
  logic         es_valid;
  logic [147:0] es_bus;
  logic         es_ready_go;

  logic [31:0] es_pc;
  logic        es_res_from_mem;
  logic        es_gr_we;
  logic        es_mem_we;
  logic [11:0] es_alu_op;
  logic [4:0]  es_dest;
  logic [31:0] es_alu_src1;
  logic [31:0] es_alu_src2;
  logic [31:0] es_rkd_value;
  logic [31:0] alu_result;

  assign es_ready_go = 1'b1;
  assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_bus <= '0;
    end else if (es_allowin && ds_to_es_valid) begin
      es_bus <= ds_to_es_bus;
`ifdef ES_BUS_SCRUB_EN
    end else if (es_allowin) begin
      es_bus <= '0;
`endif
    end
  end

  assign {es_pc, es_res_from_mem, es_gr_we, es_mem_we, es_alu_op, es_dest,
          es_alu_src1, es_alu_src2, es_rkd_value} = es_bus;

  alu u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (es_alu_src1),
    .alu_src2   (es_alu_src2),
    .alu_result (alu_result)
  );

  assign es_to_ms_valid  = es_valid & es_ready_go;
  // Payload fields are deliberately ungated; consumers qualify them with valid.
  assign es_to_ms_bus    = {es_pc, es_res_from_mem, es_gr_we, es_dest, alu_result};
  assign es_fw_bus       = {es_valid & es_res_from_mem, es_valid & es_gr_we, es_dest, alu_result};

  assign data_sram_en    = es_valid & (es_res_from_mem | es_mem_we);
  assign data_sram_we    = {4{es_valid & es_mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_rkd_value;
endmodule

// File: tb/tb_exe_stage.sv
// Randomised and directed bench for exe_stage with a queue-based scoreboard and a reference model.

module tb_exe_stage;
  logic         clk;
  logic         reset;
  logic         ds_to_es_valid;
  logic [147:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fw_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  typedef struct packed {
    logic [70:0] ms_bus;
    logic [38:0] fw_bus;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  logic m_valid_now;
  int   errors;
  int   checks;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fw_bus       (es_fw_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: ALU by operation name, one-hot op selects the operation
  function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    int sel;
    sel = -1;
    for (int i = 0; i < 12; i++) if (op[i]) sel = i;
    case (sel)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return $unsigned($signed(a) >>> b[4:0]);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [147:0] mk_bus(input logic [31:0] pc, input logic rfm, input logic gwe,
                                          input logic mwe, input logic [11:0] op, input logic [4:0] dest,
                                          input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd);
    return {pc, rfm, gwe, mwe, op, dest, s1, s2, rkd};
  endfunction

  function automatic exp_t build_exp(input logic [147:0] b);
    exp_t e;
    logic [31:0] res;
    res       = alu_model(b[112:101], b[95:64], b[63:32]);
    e.ms_bus  = {b[147:116], b[115], b[114], b[100:96], res};
    e.fw_bus  = {b[115], b[114], b[100:96], res};
    e.sram_en = b[115] | b[113];
    e.sram_we = b[113] ? 4'hF : 4'h0;
    e.addr    = res;
    e.wdata   = b[31:0];
    return e;
  endfunction

  // driver: presents one cycle of inputs and advances the model occupancy
  task automatic drive(input logic v, input logic [147:0] b, input logic ms);
    logic acc;
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = ms;
    acc = v && (!m_valid_now || ms);
    if (acc) exp_q.push_back(build_exp(b));
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid_now = 1'b1;
      last_exp    = build_exp(b);
    end else if (ms) begin
      m_valid_now = 1'b0;
    end
  endtask

  task automatic do_reset(input logic ms);
    reset          = 1'b1;
    ms_allowin     = ms;
    ds_to_es_valid = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    ds_to_es_valid = 1'b0;
    exp_q.delete();
    m_valid_now    = 1'b0;
  endtask

  function automatic logic [147:0] rand_bus();
    logic [11:0] op;
    op = 12'd1 << $urandom_range(0, 11);
    return mk_bus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  op, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
  endfunction

  // monitor: compares the DUT against the held-instruction entry at the queue front
  always @(negedge clk) begin
    if (!reset) begin
      chk("es_to_ms_valid", 148'(es_to_ms_valid), 148'(m_valid_now));
      chk("es_allowin", 148'(es_allowin), 148'(!m_valid_now || ms_allowin));
      if (!m_valid_now) begin
        chk("idle_sram_en", 148'(data_sram_en), 148'(0));
        chk("idle_sram_we", 148'(data_sram_we), 148'(0));
        chk("idle_fw_flags", 148'(es_fw_bus[38:37]), 148'(0));
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got valid instruction expected none queued");
      end else begin
        chk("es_to_ms_bus", 148'(es_to_ms_bus), 148'(exp_q[0].ms_bus));
        chk("es_fw_bus", 148'(es_fw_bus), 148'(exp_q[0].fw_bus));
        chk("sram_en", 148'(data_sram_en), 148'(exp_q[0].sram_en));
        chk("sram_we", 148'(data_sram_we), 148'(exp_q[0].sram_we));
        chk("sram_addr", 148'(data_sram_addr), 148'(exp_q[0].addr));
        chk("sram_wdata", 148'(data_sram_wdata), 148'(exp_q[0].wdata));
        if (ms_allowin) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [147:0] b;
    logic [31:0]  held_addr;
    errors = 0;
    checks = 0;
    m_valid_now    = 1'b0;
    last_exp       = '0;
    reset          = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ms_allowin     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid", 148'(es_to_ms_valid), 148'(0));
    chk("reset_allowin", 148'(es_allowin), 148'(1));
    chk("reset_sram_en", 148'(data_sram_en), 148'(0));
    chk("reset_bus", 148'(es_to_ms_bus), 148'(0));

    // add
    drive(1'b1, mk_bus(32'h1c00_0000, 1'b0, 1'b1, 1'b0, 12'h001, 5'd3, 32'd5, 32'd7, 32'd0), 1'b1);
    chk("add_valid", 148'(es_to_ms_valid), 148'(1));
    chk("add_result", 148'(es_to_ms_bus[31:0]), 148'(12));
    chk("add_fw", 148'(es_fw_bus), 148'({1'b0, 1'b1, 5'd3, 32'd12}));
    // ld.w
    drive(1'b1, mk_bus(32'h1c00_0004, 1'b1, 1'b1, 1'b0, 12'h001, 5'd4, 32'h1000, 32'h8, 32'd0), 1'b1);
    chk("ld_en", 148'(data_sram_en), 148'(1));
    chk("ld_we", 148'(data_sram_we), 148'(0));
    chk("ld_addr", 148'(data_sram_addr), 148'(32'h1008));
    chk("ld_vload", 148'(es_fw_bus[38]), 148'(1));
    // st.w
    drive(1'b1, mk_bus(32'h1c00_0008, 1'b0, 1'b0, 1'b1, 12'h001, 5'd0, 32'h20, 32'h0, 32'hDEADBEEF), 1'b1);
    chk("st_we", 148'(data_sram_we), 148'(4'hF));
    chk("st_addr", 148'(data_sram_addr), 148'(32'h20));
    chk("st_wdata", 148'(data_sram_wdata), 148'(32'hDEADBEEF));
    chk("st_vwe", 148'(es_fw_bus[37]), 148'(0));

    // stall: hold for 3 cycles while ID offers a new instruction
    drive(1'b1, mk_bus(32'h1c00_0010, 1'b1, 1'b1, 1'b0, 12'h001, 5'd7, 32'h400, 32'h4, 32'd0), 1'b1);
    held_addr = data_sram_addr;
    b = mk_bus(32'h1c00_0014, 1'b0, 1'b1, 1'b0, 12'h040, 5'd9, 32'hF0, 32'h0F, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b, 1'b0);
      chk("stall_addr", 148'(data_sram_addr), 148'(held_addr));
      chk("stall_pc", 148'(es_to_ms_bus[70:39]), 148'(32'h1c00_0010));
    end
    drive(1'b1, b, 1'b1);
    chk("after_stall_pc", 148'(es_to_ms_bus[70:39]), 148'(32'h1c00_0014));
    chk("after_stall_result", 148'(es_to_ms_bus[31:0]), 148'(32'hFF));

    // reset mid-stall with ms_allowin low
    drive(1'b1, rand_bus(), 1'b0);
    do_reset(1'b0);
    chk("rst_stall_valid", 148'(es_to_ms_valid), 148'(0));
    chk("rst_stall_allowin", 148'(es_allowin), 148'(1));
    chk("rst_stall_sram_en", 148'(data_sram_en), 148'(0));

    // drain with no new instruction
    drive(1'b1, mk_bus(32'h1c00_0020, 1'b0, 1'b1, 1'b0, 12'h002, 5'd5, 32'd50, 32'd8, 32'd1), 1'b1);
    drive(1'b0, rand_bus(), 1'b1);
    chk("drain_valid", 148'(es_to_ms_valid), 148'(0));
`ifdef ES_BUS_SCRUB_EN
    chk("drain_bus", 148'(es_to_ms_bus), 148'(0));
`else
    chk("drain_bus", 148'(es_to_ms_bus), 148'(last_exp.ms_bus));
    chk("drain_result", 148'(es_to_ms_bus[31:0]), 148'(42));
`endif

    // randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rand_bus(), ($urandom_range(0, 3) != 0));
      if (i == 200) do_reset(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    chk("final_queue_empty", 148'(exp_q.size()), 148'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
